// File: rtl/arbt_chan_mux_pkg.sv
// Shared constants and types for the four-channel arbitrated ingress mux.
package arbt_pkg;

    localparam int NCH  = 4;
    localparam int ID_W = 2;

    typedef logic [ID_W-1:0] chan_id_t;

    // True when exactly one bit of the grant vector is set.
    function automatic logic is_onehot(input logic [NCH-1:0] v);
        return (v != '0) && ((v & (v - {{(NCH-1){1'b0}}, 1'b1})) == '0);
    endfunction

endpackage

// File: rtl/arbt_chan_mux_chan_fifo.sv
// Small synchronous FIFO with a combinational head read, so a grant can pop
// the head word and forward it in the same cycle. Storage is cleared by rst
// so the head reads as zero after reset.
module chan_fifo #(
    parameter int DW    = 32,
    parameter int DEPTH = 4
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [DW-1:0]              din,
    input  logic                       rd_en,
    output logic [DW-1:0]              dout,
    output logic [$clog2(DEPTH):0]     cnt,
    output logic                       full,
    output logic                       empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [DW-1:0] mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          wr_fire, rd_fire;

    // A full FIFO refuses a write even when it is popped in the same cycle.
    assign wr_fire = wr_en && !full;
    assign rd_fire = rd_en && !empty;

    assign full  = (cnt_q == CW'(DEPTH));
    assign empty = (cnt_q == '0);
    assign cnt   = cnt_q;
    assign dout  = mem_q[rd_ptr_q];

    // Next pointers and occupancy; pointers wrap naturally at DEPTH.
    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        cnt_d    = cnt_q;
        if (wr_fire) wr_ptr_d = wr_ptr_q + AW'(1);
        if (rd_fire) rd_ptr_d = rd_ptr_q + AW'(1);
        case ({wr_fire, rd_fire})
            2'b10:   cnt_d = cnt_q + CW'(1);
            2'b01:   cnt_d = cnt_q - CW'(1);
            default: cnt_d = cnt_q;
        endcase
    end

    // Pointer and count registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            cnt_q    <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            cnt_q    <= cnt_d;
        end
    end

    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        // One storage entry, written when the write pointer selects it.
        always_ff @(posedge clk) begin
            if (rst) begin
                mem_q[gi] <= '0;
            end else if (wr_fire && (wr_ptr_q == AW'(gi))) begin
                mem_q[gi] <= din;
            end
        end
    end

endmodule

// File: rtl/arbt_chan_mux.sv
// Four-channel ingress buffer and data mux in front of a round-robin arbiter.
// Each channel has its own FIFO; a registered grant pops the winner's head
// word into a 2-entry output buffer that drains over a valid/ready port.
// Optional feature: define ARBT_CHAN_MUX_ID_TAG_EN to carry the source
// channel id alongside each output word on out_id.
module arbt_chan_mux
    import arbt_pkg::*;
#(
    parameter int DW         = 32,
    parameter int FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [NCH-1:0]    in_vld,
    output logic [NCH-1:0]    in_rdy,
    input  logic [NCH*DW-1:0] in_data,
    output logic              req0,
    output logic              req1,
    output logic              req2,
    output logic              req3,
    input  logic              gnt0,
    input  logic              gnt1,
    input  logic              gnt2,
    input  logic              gnt3,
    input  chan_id_t          gnt_id,
    output logic              out_vld,
    input  logic              out_rdy,
    output logic [DW-1:0]     out_data,
`ifdef ARBT_CHAN_MUX_ID_TAG_EN
    output chan_id_t          out_id,
`endif
    output logic              gnt_err
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef ARBT_CHAN_MUX_ID_TAG_EN
    localparam int OBW = DW + ID_W;
`else
    localparam int OBW = DW;
`endif

    logic [NCH-1:0] gnt_vec;
    logic [NCH-1:0] req_vec;
    logic [NCH-1:0] pop_vec;
    logic [NCH-1:0] chan_ok;
    logic [NCH-1:0] ch_full;
    logic [NCH-1:0] ch_empty;
    logic [DW-1:0]  ch_dout [NCH];
    logic [CW-1:0]  ch_cnt  [NCH];

    logic           err_now;
    logic           grant_fire;
    logic           gnt_err_q, gnt_err_d;

    logic [OBW-1:0] ob_din;
    logic [OBW-1:0] ob_dout;
    logic [1:0]     ob_cnt;
    logic           ob_full;
    logic           ob_empty;
    logic           ob_pop;

    assign gnt_vec = {gnt3, gnt2, gnt1, gnt0};
    assign req0    = req_vec[0];
    assign req1    = req_vec[1];
    assign req2    = req_vec[2];
    assign req3    = req_vec[3];
    assign in_rdy  = ~ch_full;

    for (genvar gi = 0; gi < NCH; gi++) begin : g_chan
        // A granted channel must be non-empty and match the arbiter's id.
        assign chan_ok[gi] = !gnt_vec[gi] || (!ch_empty[gi] && (gnt_id == chan_id_t'(gi)));
        // Request only from registered counts: data waiting and room downstream.
        assign req_vec[gi] = (ch_cnt[gi] != '0) && (ob_cnt != 2'd2);
        assign pop_vec[gi] = grant_fire && gnt_vec[gi];

        chan_fifo #(
            .DW    (DW),
            .DEPTH (FIFO_DEPTH)
        ) u_fifo (
            .clk   (clk),
            .rst   (rst),
            .wr_en (in_vld[gi]),
            .din   (in_data[gi*DW +: DW]),
            .rd_en (pop_vec[gi]),
            .dout  (ch_dout[gi]),
            .cnt   (ch_cnt[gi]),
            .full  (ch_full[gi]),
            .empty (ch_empty[gi])
        );
    end

    // Grant qualification: any protocol violation blocks the transfer entirely.
    always_comb begin
        err_now    = 1'b0;
        grant_fire = 1'b0;
        if (gnt_vec != '0) begin
            err_now    = !is_onehot(gnt_vec) || ob_full || !(&chan_ok);
            grant_fire = !err_now && !rst;
        end
    end

`ifdef ARBT_CHAN_MUX_ID_TAG_EN
    assign ob_din   = {gnt_id, ch_dout[gnt_id]};
    assign out_data = ob_dout[DW-1:0];
    assign out_id   = ob_dout[OBW-1:DW];
`else
    assign ob_din   = ch_dout[gnt_id];
    assign out_data = ob_dout;
`endif

    assign out_vld = !ob_empty;
    assign ob_pop  = out_vld && out_rdy;

    chan_fifo #(
        .DW    (OBW),
        .DEPTH (2)
    ) u_obuf (
        .clk   (clk),
        .rst   (rst),
        .wr_en (grant_fire),
        .din   (ob_din),
        .rd_en (ob_pop),
        .dout  (ob_dout),
        .cnt   (ob_cnt),
        .full  (ob_full),
        .empty (ob_empty)
    );

    assign gnt_err_d = gnt_err_q || err_now;
    assign gnt_err   = gnt_err_q;

    // Sticky error flag, cleared only by reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            gnt_err_q <= 1'b0;
        end else begin
            gnt_err_q <= gnt_err_d;
        end
    end

endmodule

// File: tb/tb_arbt_chan_mux.sv
// Randomized and directed bench for arbt_chan_mux with a behavioural
// round-robin arbiter and a queue-based reference of the buffering.
module tb_arbt_chan_mux;
    import arbt_pkg::*;

    localparam int DW    = 32;
    localparam int DEPTH = 4;

    logic              clk = 1'b0;
    logic              rst;
    logic [NCH-1:0]    in_vld;
    logic [NCH-1:0]    in_rdy;
    logic [NCH*DW-1:0] in_data;
    logic              req0, req1, req2, req3;
    logic              gnt0, gnt1, gnt2, gnt3;
    chan_id_t          gnt_id;
    logic              out_vld;
    logic              out_rdy;
    logic [DW-1:0]     out_data;
`ifdef ARBT_CHAN_MUX_ID_TAG_EN
    chan_id_t          out_id;
`endif
    logic              gnt_err;

    always #5 clk = ~clk;

    arbt_chan_mux #(.DW(DW), .FIFO_DEPTH(DEPTH)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_vld   (in_vld),
        .in_rdy   (in_rdy),
        .in_data  (in_data),
        .req0     (req0),
        .req1     (req1),
        .req2     (req2),
        .req3     (req3),
        .gnt0     (gnt0),
        .gnt1     (gnt1),
        .gnt2     (gnt2),
        .gnt3     (gnt3),
        .gnt_id   (gnt_id),
        .out_vld  (out_vld),
        .out_rdy  (out_rdy),
        .out_data (out_data),
`ifdef ARBT_CHAN_MUX_ID_TAG_EN
        .out_id   (out_id),
`endif
        .gnt_err  (gnt_err)
    );

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference state: per-channel word queues plus the output buffer.
    typedef logic [DW-1:0] wq_t [$];
    wq_t        mq [NCH];
    logic [DW-1:0] ob_data_q [$];
    logic [1:0]    ob_id_q   [$];
    bit         m_err    = 1'b0;
    bit         ob_clean = 1'b1;
    int         arb_pend = -1;
    int         arb_last = NCH - 1;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s cyc=%0d got=%0h want=%0h", tag, cyc, obs, exp);
        end
    endtask

    function automatic bit model_req(input int n);
        return (mq[n].size() != 0) && (ob_data_q.size() != 2);
    endfunction

    task automatic check_outputs();
        logic [3:0] exp_rdy;
        logic [3:0] exp_req;
        for (int n = 0; n < NCH; n++) begin
            exp_rdy[n] = (mq[n].size() < DEPTH);
            exp_req[n] = model_req(n);
        end
        check_eq("in_rdy", 64'(in_rdy), 64'(exp_rdy));
        check_eq("req", 64'({req3, req2, req1, req0}), 64'(exp_req));
        check_eq("out_vld", 64'(out_vld), 64'(ob_data_q.size() != 0));
        if (ob_data_q.size() != 0) begin
            check_eq("out_data", 64'(out_data), 64'(ob_data_q[0]));
`ifdef ARBT_CHAN_MUX_ID_TAG_EN
            check_eq("out_id", 64'(out_id), 64'(ob_id_q[0]));
`endif
        end else if (ob_clean) begin
            check_eq("out_data_rst", 64'(out_data), 64'd0);
`ifdef ARBT_CHAN_MUX_ID_TAG_EN
            check_eq("out_id_rst", 64'(out_id), 64'd0);
`endif
        end
        check_eq("gnt_err", 64'(gnt_err), 64'(m_err));
    endtask

    // One clock cycle: check outputs, drive inputs, advance the reference.
    task automatic step(input logic [3:0] vld, input logic [NCH*DW-1:0] data,
                        input logic rdy, input bit use_arb,
                        input logic [3:0] fgnt, input logic [1:0] fid, input logic r);
        logic [3:0] g;
        logic [1:0] gid;
        logic [3:0] acc;
        bit         ok;
        int         next_pend;
        int         n;
        @(negedge clk);
        cyc++;
        check_outputs();
        if (use_arb) begin
            g   = (arb_pend >= 0) ? (4'b0001 << arb_pend) : 4'b0000;
            gid = (arb_pend >= 0) ? 2'(arb_pend) : 2'd0;
        end else begin
            g   = fgnt;
            gid = fid;
        end
        rst     = r;
        in_vld  = vld;
        in_data = data;
        out_rdy = rdy;
        {gnt3, gnt2, gnt1, gnt0} = g;
        gnt_id  = gid;

        // Arbiter: registered grant, never decides while a grant is live.
        next_pend = -1;
        if (r) begin
            arb_last = NCH - 1;
        end else if (use_arb && g == 4'b0000) begin
            for (int k = 1; k <= NCH; k++) begin
                n = (arb_last + k) % NCH;
                if (next_pend < 0 && model_req(n)) next_pend = n;
            end
            if (next_pend >= 0) arb_last = next_pend;
        end
        arb_pend = next_pend;

        if (r) begin
            for (int c = 0; c < NCH; c++) mq[c].delete();
            ob_data_q.delete();
            ob_id_q.delete();
            m_err    = 1'b0;
            ob_clean = 1'b1;
        end else begin
            for (int c = 0; c < NCH; c++) acc[c] = vld[c] && (mq[c].size() < DEPTH);
            ok = ($countones(g) == 1) && g[gid] && (mq[gid].size() != 0) && (ob_data_q.size() < 2);
            if (ob_data_q.size() != 0 && rdy) begin
                $display("OUT cyc=%0d ch=%0d data=%08h", cyc, ob_id_q[0], ob_data_q[0]);
                void'(ob_data_q.pop_front());
                void'(ob_id_q.pop_front());
            end
            if (ok) begin
                ob_data_q.push_back(mq[gid].pop_front());
                ob_id_q.push_back(gid);
                ob_clean = 1'b0;
            end else if (g != 4'b0000) begin
                m_err = 1'b1;
                $display("GNT_ERR_EVENT cyc=%0d gnt=%b id=%0d", cyc, g, gid);
            end
            for (int c = 0; c < NCH; c++)
                if (acc[c]) mq[c].push_back(data[c*DW +: DW]);
        end
    endtask

    task automatic idle(input int cnt, input logic rdy);
        for (int i = 0; i < cnt; i++) step(4'b0, '0, rdy, 1'b1, 4'b0, 2'd0, 1'b0);
    endtask

    function automatic logic [NCH*DW-1:0] rand_data();
        logic [NCH*DW-1:0] d;
        for (int c = 0; c < NCH; c++) d[c*DW +: DW] = $urandom;
        return d;
    endfunction

    initial begin
        logic [NCH*DW-1:0] d;
        rst     = 1'b1;
        in_vld  = '0;
        in_data = '0;
        out_rdy = 1'b0;
        {gnt3, gnt2, gnt1, gnt0} = 4'b0;
        gnt_id  = '0;
        repeat (2) @(posedge clk);

        // Single word on channel 2 through the full latency path.
        d = '0;
        d[2*DW +: DW] = 32'hA5A5_0001;
        step(4'b0100, d, 1'b1, 1'b1, 4'b0, 2'd0, 1'b0);
        idle(6, 1'b1);

        // Round robin: two words per channel.
        step(4'hF, rand_data(), 1'b1, 1'b1, 4'b0, 2'd0, 1'b0);
        step(4'hF, rand_data(), 1'b1, 1'b1, 4'b0, 2'd0, 1'b0);
        idle(22, 1'b1);

        // Backpressure: load everything with the sink stalled, then release.
        for (int i = 0; i < 4; i++) step(4'hF, rand_data(), 1'b0, 1'b1, 4'b0, 2'd0, 1'b0);
        idle(12, 1'b0);
        idle(40, 1'b1);

        // Full FIFO on channel 1 without grants, a 5th write refused, then one grant.
        for (int i = 0; i < 5; i++) step(4'b0010, rand_data(), 1'b1, 1'b0, 4'b0, 2'd0, 1'b0);
        step(4'b0, '0, 1'b1, 1'b0, 4'b0010, 2'd1, 1'b0);
        step(4'b0, '0, 1'b1, 1'b0, 4'b0, 2'd0, 1'b0);
        idle(14, 1'b1);

        // Protocol errors: grant on empty channel 3, then id mismatch.
        step(4'b0001, rand_data(), 1'b0, 1'b0, 4'b0, 2'd0, 1'b0);
        step(4'b0, '0, 1'b0, 1'b0, 4'b1000, 2'd3, 1'b0);
        step(4'b0, '0, 1'b0, 1'b0, 4'b0, 2'd0, 1'b0);
        step(4'b0, '0, 1'b0, 1'b0, 4'b0001, 2'd1, 1'b0);
        step(4'b0, '0, 1'b0, 1'b0, 4'b0, 2'd0, 1'b0);
        step(4'b0, '0, 1'b0, 1'b0, 4'b0011, 2'd0, 1'b0);
        idle(3, 1'b0);

        // Reset mid-stream with words buffered, grant in flight during reset.
        step(4'hF, rand_data(), 1'b0, 1'b1, 4'b0, 2'd0, 1'b0);
        idle(6, 1'b0);
        step(4'b0, '0, 1'b0, 1'b0, 4'b0001, 2'd0, 1'b1);
        idle(4, 1'b1);

        // Randomized traffic with occasional illegal grants and resets.
        for (int i = 0; i < 1500; i++) begin
            if (i % 300 == 299) begin
                step(4'($urandom), rand_data(), 1'b1, 1'b1, 4'b0, 2'd0, 1'b1);
            end else if (i % 250 == 120) begin
                step(4'($urandom), rand_data(), 1'($urandom), 1'b0,
                     4'($urandom_range(1, 15)), 2'($urandom), 1'b0);
            end else begin
                step(4'($urandom), rand_data(), ($urandom % 4) != 0, 1'b1, 4'b0, 2'd0, 1'b0);
            end
        end
        idle(30, 1'b1);
        @(negedge clk);
        check_outputs();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
